updown_mod_counter: RTL and testbench

Parametrised up/down modulo counter. It is the next generation of the lab's fixed 8-bit T-flip-flop enable counter and adds:
- configurable width and terminal value;
- direction control;
- synchronous parallel load;
- an internal prescaler;
- registered wrap and step strobes.

It sits between the board inputs (KEY/SW) and the hex display decoders, and its Q nibbles feed the existing 7-segment decoders unchanged.

---
 rtl/updown_mod_counter.sv | 128 ++++++++++++
 tb/tb_updown_mod_counter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// -----------------------------------------------------------------------------
// updown_mod_counter
//
// Parametrised up/down modulo counter with an internal prescaler. The count
// runs over 0..MAX and wraps in either direction. A synchronous parallel load
// clamps its value to MAX. Step and Tc are registered one-cycle strobes: Step
// marks that Q stepped, and Tc marks that Q wrapped.
//
// Parameters
//   WIDTH    : counter width in bits (1..16)
//   MAX      : terminal value, count range 0..MAX (1..2^WIDTH-1)
//   PRESCALE : enabled clocks per count step (1..65535)
//
// Ports
//   clock   : rising-edge clock
//   Clear_b : synchronous active-low clear (Q, prescaler, Step, Tc -> 0)
//   Enable  : advances prescaler and counter while high
//   Up      : 1 = increment, 0 = decrement, sampled on each step edge
//   Load    : synchronous parallel load of D (clamped to MAX)
//   D       : load value
//   Q       : current count
//   Step    : high for the one cycle after an edge on which Q stepped
//   Tc      : high for the one cycle after an edge on which Q wrapped
// -----------------------------------------------------------------------------
module updown_mod_counter #(
   parameter int WIDTH    = 8,
   parameter int MAX      = 255,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             Clear_b,
   input  logic             Enable,
   input  logic             Up,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             Step,
   output logic             Tc
);

   localparam int               PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   // High when the next enabled edge is a step edge.
   logic presc_last;

   generate
      if (PRESCALE > 1) begin : g_presc
         logic [PW-1:0] presc_q;
         logic [PW-1:0] presc_d;

         // NOTE: every signal driven in always_comb gets a default first,
         // otherwise a missed branch infers a latch.
         always_comb begin
            presc_d = presc_q;
            if (Load) begin
               presc_d = '0;
            end else if (Enable) begin
               presc_d = presc_last ? '0 : presc_q + PW'(1);
            end
         end

         // NOTE: state registers use non-blocking assignments only, so every
         // flop samples the values from before the edge.
         always_ff @(posedge clock) begin
            if (!Clear_b) begin
               presc_q <= '0;
            end else begin
               presc_q <= presc_d;
            end
         end

         assign presc_last = (presc_q == PW'(PRESCALE - 1));
      end else begin : g_no_presc
         // With no prescaler, every enabled edge is a step edge.
         assign presc_last = 1'b1;
      end
   endgenerate

   logic [WIDTH-1:0] q_q, q_d;
   logic             step_q, step_d;
   logic             tc_q, tc_d;

   // Load outranks Enable. Clear is applied in the register block, so it
   // outranks both. Step and Tc default low, which makes them one-cycle pulses.
   always_comb begin
      q_d    = q_q;
      step_d = 1'b0;
      tc_d   = 1'b0;
      if (Load) begin
         q_d = (D > MAX_V) ? MAX_V : D;
      end else if (Enable && presc_last) begin
         step_d = 1'b1;
         if (Up) begin
            if (q_q == MAX_V) begin
               q_d  = '0;
               tc_d = 1'b1;
            end else begin
               q_d = q_q + WIDTH'(1);
            end
         end else begin
            if (q_q == '0) begin
               q_d  = MAX_V;
               tc_d = 1'b1;
            end else begin
               q_d = q_q - WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!Clear_b) begin
         q_q    <= '0;
         step_q <= 1'b0;
         tc_q   <= 1'b0;
      end else begin
         q_q    <= q_d;
         step_q <= step_d;
         tc_q   <= tc_d;
      end
   end

   assign Q    = q_q;
   assign Step = step_q;
   assign Tc   = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_updown_mod_counter
//
// Four counter configurations share one set of stimulus inputs:
//   a: WIDTH 8, MAX 255, PRESCALE 1
//   b: WIDTH 4, MAX 9,   PRESCALE 4
//   c: WIDTH 4, MAX 9,   PRESCALE 1
//   d: WIDTH 8, MAX 200, PRESCALE 5
// An arithmetic reference model tracks each configuration.
// -----------------------------------------------------------------------------
module tb_updown_mod_counter;

   localparam int N_DUT = 4;
   localparam int P_W   [N_DUT] = '{8, 4, 4, 8};
   localparam int P_MAX [N_DUT] = '{255, 9, 9, 200};
   localparam int P_PRE [N_DUT] = '{1, 4, 1, 5};

   logic       clock;
   logic       clear_b;
   logic       enable;
   logic       up;
   logic       load;
   logic [7:0] d;

   logic [7:0] q_a, q_d;
   logic [3:0] q_b, q_c;
   logic       step_a, step_b, step_c, step_d;
   logic       tc_a, tc_b, tc_c, tc_d;

   updown_mod_counter #(.WIDTH(8), .MAX(255), .PRESCALE(1)) u_a (
      .clock(clock), .Clear_b(clear_b), .Enable(enable), .Up(up), .Load(load),
      .D(d), .Q(q_a), .Step(step_a), .Tc(tc_a));

   updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(4)) u_b (
      .clock(clock), .Clear_b(clear_b), .Enable(enable), .Up(up), .Load(load),
      .D(d[3:0]), .Q(q_b), .Step(step_b), .Tc(tc_b));

   updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1)) u_c (
      .clock(clock), .Clear_b(clear_b), .Enable(enable), .Up(up), .Load(load),
      .D(d[3:0]), .Q(q_c), .Step(step_c), .Tc(tc_c));

   updown_mod_counter #(.WIDTH(8), .MAX(200), .PRESCALE(5)) u_d (
      .clock(clock), .Clear_b(clear_b), .Enable(enable), .Up(up), .Load(load),
      .D(d), .Q(q_d), .Step(step_d), .Tc(tc_d));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------------------------------------------------------- scoring
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      int q;
      int phase;
      bit step;
      bit tc;
   } mdl_t;

   mdl_t mdl [N_DUT];

   function automatic void mdl_edge(inout mdl_t m, input int max, input int pre,
                                    input bit clr_n, input bit ld, input bit en,
                                    input bit dir_up, input int dv);
      m.step = 1'b0;
      m.tc   = 1'b0;
      if (!clr_n) begin
         m.q     = 0;
         m.phase = 0;
      end else if (ld) begin
         m.q     = (dv > max) ? max : dv;
         m.phase = 0;
      end else if (en) begin
         m.phase = m.phase + 1;
         if (m.phase == pre) begin
            m.phase = 0;
            m.step  = 1'b1;
            if (dir_up) begin
               m.tc = (m.q == max);
               m.q  = (m.q + 1) % (max + 1);
            end else begin
               m.tc = (m.q == 0);
               m.q  = (m.q + max) % (max + 1);
            end
         end
      end
   endfunction

   task automatic compare_all();
      check("a_q",    int'(q_a),    mdl[0].q);
      check("a_step", int'(step_a), int'(mdl[0].step));
      check("a_tc",   int'(tc_a),   int'(mdl[0].tc));
      check("b_q",    int'(q_b),    mdl[1].q);
      check("b_step", int'(step_b), int'(mdl[1].step));
      check("b_tc",   int'(tc_b),   int'(mdl[1].tc));
      check("c_q",    int'(q_c),    mdl[2].q);
      check("c_step", int'(step_c), int'(mdl[2].step));
      check("c_tc",   int'(tc_c),   int'(mdl[2].tc));
      check("d_q",    int'(q_d),    mdl[3].q);
      check("d_step", int'(step_d), int'(mdl[3].step));
      check("d_tc",   int'(tc_d),   int'(mdl[3].tc));
   endtask

   // Drive inputs, take one rising edge, advance the models, then compare
   // 1 ns after the edge.
   task automatic apply(input bit clr_n, input bit ld, input bit en,
                        input bit dir_up, input int dv);
      clear_b = clr_n;
      load    = ld;
      enable  = en;
      up      = dir_up;
      d       = 8'(dv);
      @(posedge clock);
      for (int i = 0; i < N_DUT; i++) begin
         mdl_edge(mdl[i], P_MAX[i], P_PRE[i], clr_n, ld, en, dir_up,
                  dv & ((1 << P_W[i]) - 1));
      end
      #1;
      compare_all();
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      bit clr_n;
      bit ld;
      bit en;
      bit dir_up;
      int dv;
      int exp_q;
      bit exp_step;
      bit exp_tc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input bit clr_n, input bit ld, input bit en,
                               input bit dir_up, input int dv, input int exp_q,
                               input bit exp_step, input bit exp_tc);
      vec_t v;
      v = '{clr_n, ld, en, dir_up, dv, exp_q, exp_step, exp_tc};
      vecs.push_back(v);
   endfunction

   int tc_cnt;

   initial begin
      for (int i = 0; i < N_DUT; i++) mdl[i] = '{0, 0, 1'b0, 1'b0};
      clear_b = 1'b0;
      load    = 1'b0;
      enable  = 1'b0;
      up      = 1'b1;
      d       = '0;

      // Vectors for configuration b (MAX 9, PRESCALE 4).
      add(0, 1, 1, 1,  7, 0, 0, 0);   // clear dominates load
      add(0, 0, 0, 1,  0, 0, 0, 0);
      add(1, 0, 1, 1,  0, 0, 0, 0);   // enable pattern 1,1,0,1,1,...
      add(1, 0, 1, 1,  0, 0, 0, 0);
      add(1, 0, 0, 1,  0, 0, 0, 0);
      add(1, 0, 1, 1,  0, 0, 0, 0);
      add(1, 0, 1, 1,  0, 1, 1, 0);   // 4th enabled, 5th edge
      for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 0, 1, 0, 0);
      add(1, 0, 1, 1,  0, 2, 1, 0);   // four enabled edges later
      add(1, 0, 0, 1,  0, 2, 0, 0);
      add(1, 1, 1, 1,  5, 5, 0, 0);   // load
      add(1, 1, 1, 1, 12, 9, 0, 0);   // load clamps to MAX
      for (int i = 0; i < 3; i++) add(1, 0, 1, 1, 0, 9, 0, 0);
      add(1, 1, 1, 1,  3, 3, 0, 0);   // load beats the step (and wrap)
      add(1, 0, 1, 1,  0, 3, 0, 0);
      add(1, 0, 1, 1,  0, 3, 0, 0);
      add(1, 0, 1, 0,  0, 3, 0, 0);   // direction flips mid-phase
      add(1, 0, 1, 0,  0, 2, 1, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 2, 0, 0);
      add(1, 0, 1, 0,  0, 1, 1, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 1, 0, 0);
      add(1, 0, 1, 0,  0, 0, 1, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 1, 0, 0, 0, 0, 0);
      add(1, 0, 1, 0,  0, 9, 1, 1);   // down wrap 0 -> MAX
      add(1, 0, 0, 0,  0, 9, 0, 0);

      foreach (vecs[i]) begin
         apply(vecs[i].clr_n, vecs[i].ld, vecs[i].en, vecs[i].dir_up, vecs[i].dv);
         check($sformatf("vec%0d_q", i),    int'(q_b),    vecs[i].exp_q);
         check($sformatf("vec%0d_step", i), int'(step_b), int'(vecs[i].exp_step));
         check($sformatf("vec%0d_tc", i),   int'(tc_b),   int'(vecs[i].exp_tc));
      end

      // Reset, then count up for 260 clocks on configuration a.
      apply(0, 0, 0, 1, 0);
      apply(0, 0, 0, 1, 0);
      check("up_reset_q", int'(q_a), 0);
      tc_cnt = 0;
      for (int i = 0; i < 260; i++) begin
         apply(1, 0, 1, 1, 0);
         check("up_seq_q", int'(q_a), (i + 1) % 256);
         check("up_step", int'(step_a), 1);
         if (tc_a) tc_cnt++;
      end
      check("up_tc_count", tc_cnt, 1);
      check("up_final_q", int'(q_a), 4);

      // Count down from reset on configuration c (MAX 9).
      apply(0, 0, 0, 0, 0);
      tc_cnt = 0;
      for (int k = 1; k <= 21; k++) begin
         apply(1, 0, 1, 0, 0);
         check("dn_seq_q", int'(q_c), (10 - (k % 10)) % 10);
         check("dn_tc", int'(tc_c), (k % 10 == 1) ? 1 : 0);
         if (tc_c) tc_cnt++;
      end
      check("dn_tc_count", tc_cnt, 3);

      // Clear mid-count at Q = 0x3A, prescaler phase 2, on configuration d.
      apply(1, 1, 0, 1, 8'h3A);
      check("mid_load_q", int'(q_d), 8'h3A);
      apply(1, 0, 1, 1, 0);
      apply(1, 0, 1, 1, 0);
      apply(0, 0, 1, 1, 0);
      check("mid_clear_q", int'(q_d), 0);
      for (int i = 1; i <= 5; i++) begin
         apply(1, 0, 1, 1, 0);
         check("mid_restart_q", int'(q_d), (i == 5) ? 1 : 0);
         check("mid_restart_step", int'(step_d), (i == 5) ? 1 : 0);
      end

      // Randomised traffic against the model.
      apply(0, 0, 0, 1, 0);
      for (int i = 0; i < 2000; i++) begin
         apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 255)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
